// File: rtl/bp_pkg.sv
// bp_pkg: shared counter encodings, saturating helpers and index-width derivation for the branch predictor.
package bp_pkg;
  typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} cnt_t;
  function automatic int idx_w(input int entries);
    return $clog2(entries);
  endfunction
  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return c == ST ? c : c + 2'd1;
  endfunction
  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return c == SNT ? c : c - 2'd1;
  endfunction
endpackage

// File: rtl/branch_predictor_if.sv
// branch_predictor_if: fetch lookup, execute training and statistics signals of the branch predictor.
interface branch_predictor_if;
  logic [31:0] pc_if;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_is_jump;
  logic        upd_mispred;
  logic        bp_flush;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispred;
  modport master (
    output pc_if, upd_valid, upd_pc, upd_taken, upd_target, upd_is_jump, upd_mispred, bp_flush,
    input  pred_taken, pred_target, stat_branches, stat_mispred
  );
  modport slave (
    input  pc_if, upd_valid, upd_pc, upd_taken, upd_target, upd_is_jump, upd_mispred, bp_flush,
    output pred_taken, pred_target, stat_branches, stat_mispred
  );
endinterface

// File: rtl/bp_sat_cnt.sv
// bp_sat_cnt: 2-bit saturating direction counter with load; load beats inc, inc beats dec.
module bp_sat_cnt
  import bp_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [1:0] load_val,
  input  logic       inc,
  input  logic       dec,
  output logic [1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= SNT;
    else if (load) cnt <= load_val;
    else if (inc) cnt <= sat_inc(cnt);
    else if (dec) cnt <= sat_dec(cnt);
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit counters, combinational lookup, trained from EX.
// Optional statistics counters enabled by defining BP_STATS_EN.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int         ENTRIES   = 16,
  parameter int         TAG_W     = 8,
  parameter logic [1:0] CNT_ALLOC = 2'b10
) (
  input logic clk,
  input logic rst_n,
  branch_predictor_if.slave bp
);
  localparam int IDX_W = idx_w(ENTRIES);
  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tag    [ENTRIES];
  logic [31:0]        target [ENTRIES];
  logic [1:0]         cnt    [ENTRIES];
  logic [IDX_W-1:0]   l_idx, u_idx;
  logic [TAG_W-1:0]   l_tag, u_tag;
  logic               l_hit, u_hit, do_upd, alloc, hit_cond, hit_jump;
  assign l_idx = bp.pc_if[IDX_W+1:2];
  assign l_tag = bp.pc_if[IDX_W+TAG_W+1:IDX_W+2];
  assign u_idx = bp.upd_pc[IDX_W+1:2];
  assign u_tag = bp.upd_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign l_hit = valid[l_idx] && tag[l_idx] == l_tag;
  assign u_hit = valid[u_idx] && tag[u_idx] == u_tag;
  assign bp.pred_taken  = l_hit && cnt[l_idx][1];
  assign bp.pred_target = bp.pred_taken ? target[l_idx] : bp.pc_if + 32'd4;
  // A flush in the same cycle suppresses the whole update, not just allocation.
  assign do_upd   = bp.upd_valid && !bp.bp_flush;
  assign alloc    = do_upd && !u_hit && bp.upd_taken;
  assign hit_cond = do_upd && u_hit && !bp.upd_is_jump;
  assign hit_jump = do_upd && u_hit && bp.upd_is_jump;
  for (genvar i = 0; i < ENTRIES; i++) begin : g_cnt
    logic sel;
    assign sel = u_idx == IDX_W'(i);
    bp_sat_cnt u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (sel && (alloc || hit_jump)),
      .load_val (bp.upd_is_jump ? ST : CNT_ALLOC),
      .inc      (sel && hit_cond && bp.upd_taken),
      .dec      (sel && hit_cond && !bp.upd_taken),
      .cnt      (cnt[i])
    );
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag[i]    <= '0;
        target[i] <= '0;
      end
    end else if (bp.bp_flush) valid <= '0;
    else if (bp.upd_valid) begin
      if (bp.upd_taken || (u_hit && bp.upd_is_jump)) target[u_idx] <= bp.upd_target;
      if (alloc) begin
        valid[u_idx] <= 1'b1;
        tag[u_idx]   <= u_tag;
      end
    end
`ifdef BP_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bp.stat_branches <= '0;
      bp.stat_mispred  <= '0;
    end else if (bp.upd_valid) begin
      if (bp.stat_branches != 32'hFFFF_FFFF) bp.stat_branches <= bp.stat_branches + 32'd1;
      if (bp.upd_mispred && bp.stat_mispred != 32'hFFFF_FFFF) bp.stat_mispred <= bp.stat_mispred + 32'd1;
    end
  logic unused;
  assign unused = ^{bp.pc_if[1:0], bp.pc_if[31:IDX_W+TAG_W+2], bp.upd_pc[1:0], bp.upd_pc[31:IDX_W+TAG_W+2]};
`else
  assign bp.stat_branches = '0;
  assign bp.stat_mispred  = '0;
  logic unused;
  assign unused = ^{bp.pc_if[1:0], bp.pc_if[31:IDX_W+TAG_W+2], bp.upd_pc[1:0], bp.upd_pc[31:IDX_W+TAG_W+2],
                    bp.upd_mispred};
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed self-checking bench for branch_predictor (ENTRIES=16, TAG_W=8).
module tb_branch_predictor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  branch_predictor_if bp ();
  branch_predictor #(.ENTRIES(16), .TAG_W(8), .CNT_ALLOC(2'b10)) dut (.clk(clk), .rst_n(rst_n), .bp(bp));
  always #5 clk = ~clk;

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                     input logic jmp, input logic mis, input logic fl);
    bp.upd_valid = 1'b1; bp.upd_pc = pc; bp.upd_taken = tk; bp.upd_target = tgt;
    bp.upd_is_jump = jmp; bp.upd_mispred = mis; bp.bp_flush = fl;
    @(posedge clk); #1;
    bp.upd_valid = 1'b0; bp.upd_mispred = 1'b0; bp.bp_flush = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc);
    bp.pc_if = pc;
    @(negedge clk);
  endtask

  task automatic test_reset;
    bp.pc_if = 32'h40; bp.upd_valid = 0; bp.upd_pc = 0; bp.upd_taken = 0; bp.upd_target = 0;
    bp.upd_is_jump = 0; bp.upd_mispred = 0; bp.bp_flush = 0; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (bp.pred_taken !== 1'b0 || bp.pred_target !== 32'h44) begin
      $display("FAIL reset_lookup got %b/%h want 0/00000044", bp.pred_taken, bp.pred_target); fails++; end
    rst_n = 1'b1;
    look(32'h40);
    tests++;
    if (bp.pred_taken !== 1'b0 || bp.pred_target !== 32'h44 || bp.stat_branches !== 0 || bp.stat_mispred !== 0) begin
      $display("FAIL post_reset got %b/%h stats %0d/%0d want 0/00000044 0/0", bp.pred_taken, bp.pred_target,
               bp.stat_branches, bp.stat_mispred); fails++; end
  endtask

  task automatic test_alloc;
    bp.pc_if = 32'h40;
    bp.upd_valid = 1; bp.upd_pc = 32'h40; bp.upd_taken = 1; bp.upd_target = 32'h100; bp.upd_is_jump = 0;
    #1;
    tests++;
    if (bp.pred_taken !== 1'b0 || bp.pred_target !== 32'h44) begin
      $display("FAIL same_cycle_preupdate got %b/%h want 0/00000044", bp.pred_taken, bp.pred_target); fails++; end
    @(posedge clk); #1; bp.upd_valid = 0;
    look(32'h40);
    tests++;
    if (bp.pred_taken !== 1'b1 || bp.pred_target !== 32'h100) begin
      $display("FAIL alloc_cond got %b/%h want 1/00000100", bp.pred_taken, bp.pred_target); fails++; end
  endtask

  task automatic test_train;
    upd(32'h40, 0, 0, 0, 0, 0); look(32'h40);
    tests++;
    if (bp.pred_taken !== 1'b0 || bp.pred_target !== 32'h44) begin
      $display("FAIL train_nt1 got %b/%h want 0/00000044", bp.pred_taken, bp.pred_target); fails++; end
    upd(32'h40, 0, 0, 0, 0, 0);
    upd(32'h40, 0, 0, 0, 0, 0);
    upd(32'h40, 1, 32'h100, 0, 0, 0); look(32'h40);
    tests++;
    if (bp.pred_taken !== 1'b0 || bp.pred_target !== 32'h44) begin
      $display("FAIL train_sat_low got %b/%h want 0/00000044", bp.pred_taken, bp.pred_target); fails++; end
    upd(32'h40, 1, 32'h100, 0, 0, 0); look(32'h40);
    tests++;
    if (bp.pred_taken !== 1'b1 || bp.pred_target !== 32'h100) begin
      $display("FAIL train_t_again got %b/%h want 1/00000100", bp.pred_taken, bp.pred_target); fails++; end
    upd(32'h40, 1, 32'h100, 0, 0, 0);
    upd(32'h40, 1, 32'h100, 0, 0, 0);
    upd(32'h40, 0, 0, 0, 0, 0); look(32'h40);
    tests++;
    if (bp.pred_taken !== 1'b1 || bp.pred_target !== 32'h100) begin
      $display("FAIL train_sat_high got %b/%h want 1/00000100", bp.pred_taken, bp.pred_target); fails++; end
  endtask

  task automatic test_alias;
    look(32'h80);
    tests++;
    if (bp.pred_taken !== 1'b0 || bp.pred_target !== 32'h84) begin
      $display("FAIL alias_miss got %b/%h want 0/00000084", bp.pred_taken, bp.pred_target); fails++; end
    upd(32'h80, 1, 32'h300, 0, 0, 0); look(32'h80);
    tests++;
    if (bp.pred_taken !== 1'b1 || bp.pred_target !== 32'h300) begin
      $display("FAIL alias_replace got %b/%h want 1/00000300", bp.pred_taken, bp.pred_target); fails++; end
    look(32'h40);
    tests++;
    if (bp.pred_taken !== 1'b0 || bp.pred_target !== 32'h44) begin
      $display("FAIL alias_old_evicted got %b/%h want 0/00000044", bp.pred_taken, bp.pred_target); fails++; end
    upd(32'hC0, 0, 32'h900, 0, 0, 0); look(32'h80);
    tests++;
    if (bp.pred_taken !== 1'b1 || bp.pred_target !== 32'h300) begin
      $display("FAIL miss_nt_nochange got %b/%h want 1/00000300", bp.pred_taken, bp.pred_target); fails++; end
    upd(32'h80, 0, 0, 0, 0, 0); look(32'h80);
    tests++;
    if (bp.pred_taken !== 1'b0 || bp.pred_target !== 32'h84) begin
      $display("FAIL alloc_cnt_10 got %b/%h want 0/00000084", bp.pred_taken, bp.pred_target); fails++; end
  endtask

  task automatic test_jump_flush;
    upd(32'h200, 1, 32'h400, 1, 0, 1); look(32'h200);
    tests++;
    if (bp.pred_taken !== 1'b0 || bp.pred_target !== 32'h204) begin
      $display("FAIL flush_wins got %b/%h want 0/00000204", bp.pred_taken, bp.pred_target); fails++; end
    upd(32'h200, 1, 32'h400, 1, 0, 0); look(32'h200);
    tests++;
    if (bp.pred_taken !== 1'b1 || bp.pred_target !== 32'h400) begin
      $display("FAIL jump_alloc got %b/%h want 1/00000400", bp.pred_taken, bp.pred_target); fails++; end
    upd(32'h200, 0, 0, 0, 0, 0); look(32'h200);
    tests++;
    if (bp.pred_taken !== 1'b1 || bp.pred_target !== 32'h400) begin
      $display("FAIL jump_cnt_11 got %b/%h want 1/00000400", bp.pred_taken, bp.pred_target); fails++; end
  endtask

  task automatic test_hit_jump;
    upd(32'h44, 1, 32'h500, 0, 0, 0);
    upd(32'h44, 0, 0, 0, 0, 0); look(32'h44);
    tests++;
    if (bp.pred_taken !== 1'b0 || bp.pred_target !== 32'h48) begin
      $display("FAIL hit_cond_dec got %b/%h want 0/00000048", bp.pred_taken, bp.pred_target); fails++; end
    upd(32'h44, 1, 32'h600, 1, 0, 0);
    upd(32'h44, 0, 0, 0, 0, 0); look(32'h44);
    tests++;
    if (bp.pred_taken !== 1'b1 || bp.pred_target !== 32'h600) begin
      $display("FAIL hit_jump_st got %b/%h want 1/00000600", bp.pred_taken, bp.pred_target); fails++; end
  endtask

  task automatic test_back_to_back;
    bp.upd_valid = 1; bp.upd_pc = 32'h48; bp.upd_taken = 1; bp.upd_target = 32'h700; bp.upd_is_jump = 0;
    @(posedge clk); #1;
    bp.upd_target = 32'h800;
    @(posedge clk); #1;
    bp.upd_valid = 0;
    upd(32'h48, 0, 0, 0, 0, 0); look(32'h48);
    tests++;
    if (bp.pred_taken !== 1'b1 || bp.pred_target !== 32'h800) begin
      $display("FAIL back_to_back got %b/%h want 1/00000800", bp.pred_taken, bp.pred_target); fails++; end
  endtask

  task automatic test_async_reset;
    look(32'h48);
    rst_n = 1'b0; #1;
    tests++;
    if (bp.pred_taken !== 1'b0 || bp.pred_target !== 32'h4C) begin
      $display("FAIL async_reset got %b/%h want 0/0000004c", bp.pred_taken, bp.pred_target); fails++; end
    @(negedge clk); rst_n = 1'b1;
    look(32'h48);
    tests++;
    if (bp.pred_taken !== 1'b0 || bp.pred_target !== 32'h4C) begin
      $display("FAIL after_async_reset got %b/%h want 0/0000004c", bp.pred_taken, bp.pred_target); fails++; end
  endtask

  task automatic test_stats;
    logic [31:0] eb, em;
`ifdef BP_STATS_EN
    eb = 32'd3; em = 32'd2;
`else
    eb = 32'd0; em = 32'd0;
`endif
    upd(32'h10, 1, 32'h20, 0, 1, 0);
    upd(32'h14, 0, 0, 0, 0, 0);
    upd(32'h18, 1, 32'h30, 0, 1, 0);
    tests++;
    if (bp.stat_branches !== eb || bp.stat_mispred !== em) begin
      $display("FAIL stats got %0d/%0d want %0d/%0d", bp.stat_branches, bp.stat_mispred, eb, em); fails++; end
    bp.bp_flush = 1; @(posedge clk); #1; bp.bp_flush = 0;
    tests++;
    if (bp.stat_branches !== eb || bp.stat_mispred !== em) begin
      $display("FAIL stats_flush got %0d/%0d want %0d/%0d", bp.stat_branches, bp.stat_mispred, eb, em); fails++; end
  endtask

  initial begin
    test_reset;
    test_alloc;
    test_train;
    test_alias;
    test_jump_flush;
    test_hit_jump;
    test_back_to_back;
    test_async_reset;
    test_stats;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
